hpam_err_monitor: RTL and testbench

- Sequential error-statistics monitor that consumes the output side of the approximate multiplier datapath built from approximate full adders (carry = a&b, sum = a^b^cin).
- Accepts operand pairs and the approximate product over a valid/ready handshake.
- Computes the exact product internally and accumulates error statistics over a programmed number of samples: error count, error-distance sum, maximum error distance.
- Sits beside the multiplier in the characterisation/test harness.

---
 rtl/hpam_err_monitor.sv | 265 ++++++++++++++++++++++++++
 tb/tb_hpam_err_monitor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpam_err_monitor.sv
// -----------------------------------------------------------------------------
// hpam_err_monitor
//
// Error-statistics monitor for the approximate multiplier datapath. Each
// accepted sample carries operands a, b and the approximate product p_approx.
// The monitor recomputes the exact product, forms the error distance
// ED = |a*b - p_approx| and accumulates statistics over a programmed number
// of samples.
//
// Pipeline for a sample accepted at edge E0:
//   E0: operands and approximate product are registered (stage 0)
//   E1: exact product and ED are registered (stage 1)
//   E2: statistics are updated
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           arms a run (IDLE/DONE only); sample_limit captured here
//   clear           returns to IDLE, zeroes stats and sat, flushes pipeline
//   sample_limit    number of samples per run (0 finishes immediately)
//   in_valid/ready  sample handshake; accept on in_valid & in_ready
//   a, b, p_approx  unsigned operands and approximate product
//   sample_cnt      samples accumulated
//   err_cnt         samples with nonzero ED
//   err_sum         saturating sum of ED
//   err_max         largest ED seen
//   sat             sticky err_sum saturation flag
//   busy, done      state is RUN/DRAIN, state is DONE
//
// Build option:
//   HPAM_ERR_HIST_EN  adds hist_bins, four saturating CNT_W counters packed
//                     low to high: ED==0, ED 1..15, ED 16..255, ED>=256.
// -----------------------------------------------------------------------------
module hpam_err_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 clear,
  input  logic [CNT_W-1:0]     sample_limit,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   p_approx,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [ACC_W-1:0]     err_sum,
  output logic [2*WIDTH-1:0]   err_max,
  output logic                 sat,
  output logic                 busy,
`ifdef HPAM_ERR_HIST_EN
  output logic [4*CNT_W-1:0]   hist_bins,
`endif
  output logic                 done
);

  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Control and statistics state
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             s0_v_q, s0_v_d;
  logic             s1_v_q, s1_v_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0] err_sum_q, err_sum_d;
  logic [PW-1:0]    err_max_q, err_max_d;
  logic             sat_q, sat_d;

  // Pipeline data (qualified by the valid bits above)
  logic [WIDTH-1:0] s0_a_q, s0_a_d;
  logic [WIDTH-1:0] s0_b_q, s0_b_d;
  logic [PW-1:0]    s0_p_q, s0_p_d;
  logic [PW-1:0]    s1_ed_q, s1_ed_d;

  logic             accept;
  logic [PW-1:0]    exact;
  logic [ACC_W:0]   sum_ext;

`ifdef HPAM_ERR_HIST_EN
  logic [3:0][CNT_W-1:0] hist_q, hist_d;
  logic [1:0]            bin;
`endif

  assign in_ready = (state_q == S_RUN) && (acc_cnt_q < limit_q);
  assign accept   = in_valid && in_ready;

  // NOTE: every always_comb output is given its hold/default value first so
  // that no path through the branches below leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    limit_d      = limit_q;
    acc_cnt_d    = acc_cnt_q;
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_sum_d    = err_sum_q;
    err_max_d    = err_max_q;
    sat_d        = sat_q;
`ifdef HPAM_ERR_HIST_EN
    hist_d       = hist_q;
    bin          = 2'd0;
`endif

    // Stage 0: capture the sample on acceptance, otherwise hold.
    s0_v_d = accept;
    s0_a_d = accept ? a        : s0_a_q;
    s0_b_d = accept ? b        : s0_b_q;
    s0_p_d = accept ? p_approx : s0_p_q;

    // Stage 1: exact product and absolute error distance.
    s1_v_d  = s0_v_q;
    exact   = PW'(s0_a_q) * PW'(s0_b_q);
    s1_ed_d = (exact >= s0_p_q) ? (exact - s0_p_q) : (s0_p_q - exact);

    if (accept) begin
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end

    // Stage 2: statistics update. The extra top bit of sum_ext is the
    // overflow indicator used to clamp err_sum.
    sum_ext = {1'b0, err_sum_q} + {{(ACC_W + 1 - PW){1'b0}}, s1_ed_q};
    if (s1_v_q) begin
      sample_cnt_d = sample_cnt_q + CNT_W'(1);
      if (s1_ed_q != '0) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (s1_ed_q > err_max_q) begin
        err_max_d = s1_ed_q;
      end
      if (sum_ext[ACC_W]) begin
        err_sum_d = '1;
        sat_d     = 1'b1;
      end else begin
        err_sum_d = sum_ext[ACC_W-1:0];
      end
`ifdef HPAM_ERR_HIST_EN
      if (s1_ed_q == '0) begin
        bin = 2'd0;
      end else if (s1_ed_q < 'd16) begin
        bin = 2'd1;
      end else if (s1_ed_q < 'd256) begin
        bin = 2'd2;
      end else begin
        bin = 2'd3;
      end
      if (hist_q[bin] != '1) begin
        hist_d[bin] = hist_q[bin] + CNT_W'(1);
      end
`endif
    end

    case (state_q)
      S_RUN: begin
        // The limit-th acceptance moves to DRAIN on that same edge, so
        // in_ready drops right after it.
        if (accept && ((acc_cnt_q + CNT_W'(1)) == limit_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Look at next-cycle valids so DONE coincides with the last stats
        // update rather than one cycle after it.
        if (!s0_v_d && !s1_v_d) begin
          state_d = S_DONE;
        end
      end
      default: begin  // S_IDLE, S_DONE: pipeline is empty here
        if (start) begin
          limit_d      = sample_limit;
          acc_cnt_d    = '0;
          sample_cnt_d = '0;
          err_cnt_d    = '0;
          err_sum_d    = '0;
          err_max_d    = '0;
          sat_d        = 1'b0;
`ifdef HPAM_ERR_HIST_EN
          hist_d       = '0;
`endif
          state_d      = (sample_limit == '0) ? S_DONE : S_RUN;
        end
      end
    endcase

    // clear overrides everything, including a simultaneous start.
    if (clear) begin
      state_d      = S_IDLE;
      limit_d      = '0;
      acc_cnt_d    = '0;
      s0_v_d       = 1'b0;
      s1_v_d       = 1'b0;
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      err_sum_d    = '0;
      err_max_d    = '0;
      sat_d        = 1'b0;
`ifdef HPAM_ERR_HIST_EN
      hist_d       = '0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      limit_q      <= '0;
      acc_cnt_q    <= '0;
      s0_v_q       <= 1'b0;
      s1_v_q       <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      err_sum_q    <= '0;
      err_max_q    <= '0;
      sat_q        <= 1'b0;
`ifdef HPAM_ERR_HIST_EN
      hist_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      limit_q      <= limit_d;
      acc_cnt_q    <= acc_cnt_d;
      s0_v_q       <= s0_v_d;
      s1_v_q       <= s1_v_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      err_sum_q    <= err_sum_d;
      err_max_q    <= err_max_d;
      sat_q        <= sat_d;
`ifdef HPAM_ERR_HIST_EN
      hist_q       <= hist_d;
`endif
    end
  end

  // NOTE: pipeline data registers carry no reset; they are only consumed
  // when the matching valid bit (which is reset) is set.
  always_ff @(posedge clk) begin
    s0_a_q  <= s0_a_d;
    s0_b_q  <= s0_b_d;
    s0_p_q  <= s0_p_d;
    s1_ed_q <= s1_ed_d;
  end

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign err_sum    = err_sum_q;
  assign err_max    = err_max_q;
  assign sat        = sat_q;
  assign busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
`ifdef HPAM_ERR_HIST_EN
  assign hist_bins  = hist_q;
`endif

endmodule

// File: tb/tb_hpam_err_monitor.sv
// -----------------------------------------------------------------------------
// Directed testbench for hpam_err_monitor (WIDTH=8, CNT_W=16, ACC_W=16 so that
// err_sum saturation is reachable in a few samples). Expected values are
// hand-computed from the exact products of the chosen operand pairs.
// -----------------------------------------------------------------------------
module tb_hpam_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic [15:0] sample_limit;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] p_approx;
  logic [15:0] sample_cnt;
  logic [15:0] err_cnt;
  logic [15:0] err_sum;
  logic [15:0] err_max;
  logic        sat;
  logic        busy;
  logic        done;
`ifdef HPAM_ERR_HIST_EN
  logic [63:0] hist_bins;
`endif

  int checks = 0;
  int errors = 0;

  hpam_err_monitor #(.WIDTH(8), .CNT_W(16), .ACC_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .clear        (clear),
    .sample_limit (sample_limit),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .p_approx     (p_approx),
    .sample_cnt   (sample_cnt),
    .err_cnt      (err_cnt),
    .err_sum      (err_sum),
    .err_max      (err_max),
    .sat          (sat),
    .busy         (busy),
`ifdef HPAM_ERR_HIST_EN
    .hist_bins    (hist_bins),
`endif
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic pulse_start(input logic [15:0] lim);
    start = 1'b1;
    sample_limit = lim;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  // Presents one sample and returns after the edge that accepts it,
  // leaving in_valid high so consecutive calls stream back-to-back.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] vp);
    int cyc = 0;
    a = va; b = vb; p_approx = vp; in_valid = 1'b1;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 20) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%0b after %0d cycles, expected 1", name, done, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    sample_limit = '0; a = '0; b = '0; p_approx = '0;
    #23;
    checks++;
    if ({sample_cnt, err_cnt, err_sum, err_max, sat, busy, done, in_ready} !== 68'd0) begin
      errors++;
      $display("FAIL reset_state: sc=%0d ec=%0d sum=%0d max=%0d sat=%0b busy=%0b done=%0b rdy=%0b, expected all 0",
               sample_cnt, err_cnt, err_sum, err_max, sat, busy, done, in_ready);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    pulse_start(16'd4);
    send(8'd255, 8'd255, 16'h0000);
    send(8'd255, 8'd255, 16'h0000);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun_busy: busy=%0b, expected 1", busy);
    end
    rst = 1'b1;
    #2;
    checks++;
    if ({sample_cnt, err_cnt, err_sum, err_max, sat, busy, done, in_ready} !== 68'd0) begin
      errors++;
      $display("FAIL midrun_reset: sc=%0d ec=%0d sum=%0d max=%0d sat=%0b busy=%0b done=%0b rdy=%0b, expected all 0",
               sample_cnt, err_cnt, err_sum, err_max, sat, busy, done, in_ready);
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sample_cnt, err_cnt, err_sum, busy, done, in_ready} !== 51'd0) begin
      errors++;
      $display("FAIL midrun_discard: sc=%0d ec=%0d sum=%0d busy=%0b done=%0b rdy=%0b, expected all 0",
               sample_cnt, err_cnt, err_sum, busy, done, in_ready);
    end
  endtask

  task automatic test_exact();
    pulse_start(16'd3);
    send(8'd3,   8'd5,   16'd15);
    send(8'd255, 8'd255, 16'd65025);
    send(8'd0,   8'd200, 16'd0);
    in_valid = 1'b0;
    wait_done("exact");
    checks++;
    if ({sample_cnt, err_cnt, err_sum, err_max, sat, busy} !== {16'd3, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL exact_stats: sc=%0d ec=%0d sum=%0d max=%0d sat=%0b busy=%0b, expected 3 0 0 0 0 0",
               sample_cnt, err_cnt, err_sum, err_max, sat, busy);
    end
  endtask

  task automatic test_err_accum();
    pulse_start(16'd2);
    send(8'd255, 8'd255, 16'hFC01);   // exact 0xFE01 -> ED 512
    send(8'd16,  8'd16,  16'h0110);   // exact 0x0100 -> ED 16
    in_valid = 1'b0;
    wait_done("accum");
    checks++;
    if ({sample_cnt, err_cnt, err_sum, err_max, sat} !== {16'd2, 16'd2, 16'd528, 16'd512, 1'b0}) begin
      errors++;
      $display("FAIL accum_stats: sc=%0d ec=%0d sum=%0d max=%0d sat=%0b, expected 2 2 528 512 0",
               sample_cnt, err_cnt, err_sum, err_max, sat);
    end
  endtask

  // Starts from DONE: start there re-arms and zeroes stats.
  task automatic test_back_to_back();
    logic [4:0] rdy_seen;
    logic [4:0] done_seen;
    int accepted = 0;
    pulse_start(16'd2);
    a = 8'd1; b = 8'd1; p_approx = 16'd3;   // ED 2 per sample
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rdy_seen[i] = in_ready;
      if (in_ready) accepted++;
      // start during RUN (edge 0) and DRAIN (edge 2) must be ignored
      start = (i == 0 || i == 2);
      sample_limit = 16'd7;
      @(posedge clk); #1;
      start = 1'b0;
      done_seen[i] = done;
    end
    in_valid = 1'b0;
    checks++;
    if (accepted != 2) begin
      errors++;
      $display("FAIL bp_accepted: accepted=%0d, expected 2", accepted);
    end
    checks++;
    if (rdy_seen !== 5'b00011) begin
      errors++;
      $display("FAIL bp_ready_pattern: got %b, expected 00011", rdy_seen);
    end
    checks++;
    if (done_seen !== 5'b11000) begin
      errors++;
      $display("FAIL bp_done_pattern: got %b, expected 11000", done_seen);
    end
    checks++;
    if ({sample_cnt, err_cnt, err_sum, err_max, busy} !== {16'd2, 16'd2, 16'd4, 16'd2, 1'b0}) begin
      errors++;
      $display("FAIL bp_stats: sc=%0d ec=%0d sum=%0d max=%0d busy=%0b, expected 2 2 4 2 0",
               sample_cnt, err_cnt, err_sum, err_max, busy);
    end
  endtask

  task automatic test_saturation();
    pulse_start(16'd3);
    checks++;
    if ({sample_cnt, err_sum, err_max} !== 48'd0) begin
      errors++;
      $display("FAIL sat_start_zero: sc=%0d sum=%0d max=%0d, expected 0 0 0", sample_cnt, err_sum, err_max);
    end
    repeat (3) send(8'd255, 8'd255, 16'h0000);   // ED 0xFE01 each
    in_valid = 1'b0;
    wait_done("sat");
    checks++;
    if ({sample_cnt, err_cnt, err_sum, err_max, sat} !== {16'd3, 16'd3, 16'hFFFF, 16'hFE01, 1'b1}) begin
      errors++;
      $display("FAIL sat_stats: sc=%0d ec=%0d sum=%h max=%h sat=%0b, expected 3 3 ffff fe01 1",
               sample_cnt, err_cnt, err_sum, err_max, sat);
    end
    pulse_clear();
    checks++;
    if ({sample_cnt, err_cnt, err_sum, err_max, sat, busy, done, in_ready} !== 68'd0) begin
      errors++;
      $display("FAIL sat_clear: sc=%0d ec=%0d sum=%0d max=%0d sat=%0b busy=%0b done=%0b rdy=%0b, expected all 0",
               sample_cnt, err_cnt, err_sum, err_max, sat, busy, done, in_ready);
    end
  endtask

  task automatic test_limit_zero_and_clear_priority();
    pulse_start(16'd0);
    in_valid = 1'b1; a = 8'd9; b = 8'd9; p_approx = 16'd0;
    checks++;
    if ({done, busy, in_ready} !== 3'b100) begin
      errors++;
      $display("FAIL limit0_state: done=%0b busy=%0b rdy=%0b, expected 1 0 0", done, busy, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (sample_cnt !== 16'd0) begin
      errors++;
      $display("FAIL limit0_cnt: sample_cnt=%0d, expected 0", sample_cnt);
    end
    start = 1'b1; clear = 1'b1; sample_limit = 16'd5;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    checks++;
    if ({done, busy, in_ready} !== 3'b000) begin
      errors++;
      $display("FAIL clear_wins: done=%0b busy=%0b rdy=%0b, expected 0 0 0", done, busy, in_ready);
    end
  endtask

  task automatic test_hist();
    pulse_start(16'd4);
    send(8'd2,   8'd3,   16'd6);      // ED 0
    send(8'd2,   8'd3,   16'd13);     // ED 7
    send(8'd10,  8'd10,  16'd0);      // ED 100
    send(8'd255, 8'd255, 16'hFC01);   // ED 512
    in_valid = 1'b0;
    wait_done("hist");
    checks++;
    if ({sample_cnt, err_cnt, err_sum, err_max, sat} !== {16'd4, 16'd3, 16'd619, 16'd512, 1'b0}) begin
      errors++;
      $display("FAIL hist_stats: sc=%0d ec=%0d sum=%0d max=%0d sat=%0b, expected 4 3 619 512 0",
               sample_cnt, err_cnt, err_sum, err_max, sat);
    end
`ifdef HPAM_ERR_HIST_EN
    checks++;
    if (hist_bins !== {16'd1, 16'd1, 16'd1, 16'd1}) begin
      errors++;
      $display("FAIL hist_bins: got %h, expected 0001000100010001", hist_bins);
    end
    pulse_clear();
    checks++;
    if (hist_bins !== 64'd0) begin
      errors++;
      $display("FAIL hist_clear: got %h, expected 0", hist_bins);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_exact();
    test_err_accum();
    test_back_to_back();
    test_saturation();
    test_limit_zero_and_clear_priority();
    test_hist();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
